// File: rtl/fpu_issue_ctrl_if.sv
// Handshake/bus bundle between the core, the FP issue sequencer and the ALU.
//   master : core/ALU side (drives request, operands, ALU results, flags_clr)
//   slave  : fpu_issue_ctrl (drives ALU strobes/operands, completion and status)
interface fpu_issue_ctrl_if;
  logic        start;
  logic [3:0]  opcode;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] alu_result;
  logic        alu_com_result;
  logic [5:0]  alu_flags;
  logic        flags_clr;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        ADD, SUB, MUL, DIV, INV, ABS, COM, BLT, BEQ, BGT;
  logic        busy;
  logic        done;
  logic        wb_en;
  logic [31:0] wb_data;
  logic        br_valid;
  logic        br_taken;
  logic        illegal;
  logic [5:0]  sticky_flags;

  modport master (
    output start, opcode, src1, src2, alu_result, alu_com_result, alu_flags, flags_clr,
    input  operand1, operand2, ADD, SUB, MUL, DIV, INV, ABS, COM, BLT, BEQ, BGT,
    input  busy, done, wb_en, wb_data, br_valid, br_taken, illegal, sticky_flags
  );

  modport slave (
    input  start, opcode, src1, src2, alu_result, alu_com_result, alu_flags, flags_clr,
    output operand1, operand2, ADD, SUB, MUL, DIV, INV, ABS, COM, BLT, BEQ, BGT,
    output busy, done, wb_en, wb_data, br_valid, br_taken, illegal, sticky_flags
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FP issue sequencer sitting directly in front of the FPU ALU.
// Accepts one op per request, latches operands, holds the ALU op strobes for an
// op-dependent number of cycles, captures result/compare/flags, then reports a
// writeback or branch outcome. Keeps an OR-accumulated sticky exception register.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - fpu_issue_ctrl_if.slave: request (start/opcode/src1/src2), ALU
//          strobes and operands, ALU results in, done/wb/branch/illegal/sticky out
module fpu_issue_ctrl #(
  parameter int BASE_LAT = 1,
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 8
) (
  input  logic          clk,
  input  logic          rst,
  fpu_issue_ctrl_if.slave bus
);
  localparam int MAX_LAT = (BASE_LAT > MUL_LAT) ?
                           ((BASE_LAT > DIV_LAT) ? BASE_LAT : DIV_LAT) :
                           ((MUL_LAT  > DIV_LAT) ? MUL_LAT  : DIV_LAT);
  localparam int CW = $clog2(MAX_LAT) + 1;

  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_BLT  = 4'd7;
  localparam logic [3:0] OP_LAST = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    op_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] lat_m1;
  logic [31:0]   opnd1_q, opnd2_q, wb_data_q;
  logic          br_taken_q, illegal_q;
  logic [5:0]    sticky_q;
  logic [9:0]    stb;
  logic          accept, capture, is_br;

  assign accept  = (state_q == S_IDLE) && bus.start && (bus.opcode <= OP_LAST);
  assign capture = (state_q == S_EXEC) && (cnt_q == '0);
  // op_q only ever holds a legal opcode, so >= BLT means BLT/BEQ/BGT
  assign is_br   = (op_q >= OP_BLT);

  always_comb begin
    lat_m1 = CW'(BASE_LAT - 1);
    if (bus.opcode == OP_MUL)      lat_m1 = CW'(MUL_LAT - 1);
    else if (bus.opcode == OP_DIV) lat_m1 = CW'(DIV_LAT - 1);
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // datapath / status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      cnt_q      <= '0;
      opnd1_q    <= '0;
      opnd2_q    <= '0;
      wb_data_q  <= '0;
      br_taken_q <= 1'b0;
      illegal_q  <= 1'b0;
      sticky_q   <= '0;
    end else begin
      illegal_q <= (state_q == S_IDLE) && bus.start && (bus.opcode > OP_LAST);
      if (accept) begin
        op_q    <= bus.opcode;
        opnd1_q <= bus.src1;
        opnd2_q <= bus.src2;
        cnt_q   <= lat_m1;
      end else if (state_q == S_EXEC && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (capture) begin
        wb_data_q  <= bus.alu_result;
        br_taken_q <= bus.alu_com_result;
        // a clear landing on the capture cycle keeps only the fresh flags
        sticky_q   <= bus.flags_clr ? bus.alu_flags : (sticky_q | bus.alu_flags);
      end else if (bus.flags_clr) begin
        sticky_q <= '0;
      end
    end
  end

  // strobes: bit index == opcode; branches also raise COM (bit 6)
  always_comb begin
    stb = '0;
    if (state_q == S_EXEC) begin
      case (op_q)
        4'd0: stb[0] = 1'b1;
        4'd1: stb[1] = 1'b1;
        4'd2: stb[2] = 1'b1;
        4'd3: stb[3] = 1'b1;
        4'd4: stb[4] = 1'b1;
        4'd5: stb[5] = 1'b1;
        4'd6: stb[6] = 1'b1;
        4'd7: begin stb[7] = 1'b1; stb[6] = 1'b1; end
        4'd8: begin stb[8] = 1'b1; stb[6] = 1'b1; end
        4'd9: begin stb[9] = 1'b1; stb[6] = 1'b1; end
        default: stb = '0;
      endcase
    end
  end

  assign bus.ADD = stb[0];
  assign bus.SUB = stb[1];
  assign bus.MUL = stb[2];
  assign bus.DIV = stb[3];
  assign bus.INV = stb[4];
  assign bus.ABS = stb[5];
  assign bus.COM = stb[6];
  assign bus.BLT = stb[7];
  assign bus.BEQ = stb[8];
  assign bus.BGT = stb[9];

  assign bus.operand1     = opnd1_q;
  assign bus.operand2     = opnd2_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.wb_en        = (state_q == S_DONE) && !is_br;
  assign bus.br_valid     = (state_q == S_DONE) && is_br;
  assign bus.wb_data      = wb_data_q;
  assign bus.br_taken     = br_taken_q;
  assign bus.illegal      = illegal_q;
  assign bus.sticky_flags = sticky_q;
endmodule
